sprite_rom_arbiter: RTL and testbench

- Shares one synchronous sprite ROM and its palette lookup among NUM_REQ sprite requesters, such as the player, enemy and bullet mappers.
- Grants at most one ROM read per vga_clk cycle, round-robin between requesters.
- Returns each ROM word to the requester that issued it, with a fixed latency.
- Sits between the per-sprite draw logic and the ROM, which is instantiated once instead of once per sprite.

---
 rtl/sprite_rom_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Lets NUM_REQ sprite requesters (player, enemy, bullet mappers, ...) share a
// single synchronous sprite ROM. At most one read is granted per vga_clk
// cycle. Each returned ROM word is steered back to the requester that issued
// it, ROM_LAT+2 cycles after its grant cycle.
//
// Configuration macro:
//   SPRITE_ARB_FIXED_PRIO_EN - when defined, the lowest requester index always
//                              wins. The round-robin pointer is removed and
//                              frame_start is ignored. Latency is unchanged.
//
// Ports:
//   vga_clk      in   single clock
//   reset        in   asynchronous, active-high reset
//   frame_start  in   one-cycle pulse; resets the round-robin pointer to 0
//   req          in   [NUM_REQ]        per-requester read request
//   req_addr     in   [NUM_REQ*ADDR_W] packed addresses; requester i uses
//                                      bits [i*ADDR_W +: ADDR_W]
//   gnt          out  [NUM_REQ]        one-hot grant, combinational from req
//   rom_address  out  [ADDR_W]         registered ROM address
//   rom_q        in   [DATA_W]         ROM read data
//   rd_valid     out  [NUM_REQ]        one-hot, registered read-data strobe
//   rd_data      out  [DATA_W]         registered read data (held when idle)
//   busy         out  high while any read is in flight
// -----------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 2,
    parameter int ROM_LAT = 1
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt_s;
    logic [ADDR_W-1:0]  gnt_addr_s;
    logic               busy_s;

    // One-hot tag per pipeline stage; stage ROM_LAT lines up with rom_q.
    logic [NUM_REQ-1:0] tag_pipe_r [ROM_LAT+1];

`ifdef SPRITE_ARB_FIXED_PRIO_EN

    logic unused_frame_start_s;
    assign unused_frame_start_s = frame_start;

    // Fixed priority: the lowest set request index wins.
    always_comb begin
        gnt_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt_s = '0;
                gnt_s[k] = 1'b1;
            end else begin
                gnt_s = gnt_s;
            end
        end
    end

`else

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] gnt_idx_s;
    logic             found_s;
    logic [PTR_W:0]   rr_sum_s;
    logic [PTR_W-1:0] rr_idx_s;

    // Round-robin search: first set request at or above the pointer, wrapping.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = '0;
        found_s   = 1'b0;
        rr_sum_s  = '0;
        rr_idx_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum_s = {1'b0, ptr_r} + (PTR_W+1)'(k);
            if (rr_sum_s >= (PTR_W+1)'(NUM_REQ)) begin
                rr_sum_s = rr_sum_s - (PTR_W+1)'(NUM_REQ);
            end else begin
                rr_sum_s = rr_sum_s;
            end
            rr_idx_s = rr_sum_s[PTR_W-1:0];
            if (!found_s && req[rr_idx_s]) begin
                gnt_s[rr_idx_s] = 1'b1;
                gnt_idx_s       = rr_idx_s;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer register: frame_start overrides the post-grant advance.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (frame_start) begin
            ptr_r <= '0;
        end else if (found_s) begin
            if (gnt_idx_s == PTR_W'(NUM_REQ - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= gnt_idx_s + PTR_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

`endif

    assign gnt = gnt_s;

    // Address mux: gnt_s is one-hot, so OR-ing the selected slices is exact.
    always_comb begin
        gnt_addr_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
                gnt_addr_s = gnt_addr_s | req_addr[i*ADDR_W +: ADDR_W];
            end else begin
                gnt_addr_s = gnt_addr_s;
            end
        end
    end

    // ROM address register, tag shift pipeline and read-data return register.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_address <= '0;
            for (int s = 0; s <= ROM_LAT; s++) begin
                tag_pipe_r[s] <= '0;
            end
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            if (|gnt_s) begin
                rom_address <= gnt_addr_s;
            end else begin
                rom_address <= rom_address;
            end
            tag_pipe_r[0] <= gnt_s;
            for (int s = 1; s <= ROM_LAT; s++) begin
                tag_pipe_r[s] <= tag_pipe_r[s-1];
            end
            rd_valid <= tag_pipe_r[ROM_LAT];
            // rd_data keeps the last returned word when nothing is returning.
            if (|tag_pipe_r[ROM_LAT]) begin
                rd_data <= rom_q;
            end else begin
                rd_data <= rd_data;
            end
        end
    end

    // busy: any tag still travelling, or a result being presented.
    always_comb begin
        busy_s = |rd_valid;
        for (int s = 0; s <= ROM_LAT; s++) begin
            busy_s = busy_s | (|tag_pipe_r[s]);
        end
    end

    assign busy = busy_s;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_rom_arbiter
//
// Directed, table-driven bench for sprite_rom_arbiter with default parameters.
// The ROM model returns q = address[1:0] one cycle after sampling. Requester
// addresses are chosen so that the low two bits equal the requester index,
// which makes rd_data equal to the index of the returning requester.
// -----------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

    logic        vga_clk;
    logic        reset;
    logic        frame_start;
    logic [3:0]  req;
    logic [35:0] req_addr;
    logic [3:0]  gnt;
    logic [8:0]  rom_address;
    logic [1:0]  rom_q;
    logic [3:0]  rd_valid;
    logic [1:0]  rd_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic       fs;
        logic [3:0] gnt;
        logic [3:0] rdv;
        logic [1:0] rdd;
        logic       busy;
        logic [8:0] addr;
    } vec_t;

    vec_t vecs [21];

    sprite_rom_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (9),
        .DATA_W  (2),
        .ROM_LAT (1)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    // Clock generation.
    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // Synchronous ROM model, one cycle latency.
    always_ff @(posedge vga_clk) begin
        rom_q <= rom_address[1:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then wait for the falling edge.
    task automatic drive(input logic [3:0] r, input logic f);
        @(posedge vga_clk);
        #1;
        req         = r;
        frame_start = f;
        @(negedge vga_clk);
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        req         = 4'b0000;
        // Requester i address has [1:0] == i.
        req_addr    = {9'd511, 9'd258, 9'd37, 9'd100};

        @(negedge vga_clk);
        check("rst gnt",      32'(gnt),         32'd0);
        check("rst rom_addr", 32'(rom_address), 32'd0);
        check("rst rd_valid", 32'(rd_valid),    32'd0);
        check("rst rd_data",  32'(rd_data),     32'd0);
        check("rst busy",     32'(busy),        32'd0);
        @(posedge vga_clk);
        #1;
        reset = 1'b0;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
        // Fixed priority: requester 1 beats 2 every cycle; frame_start ignored.
        for (int c = 0; c < 6; c++) begin
            drive(4'b0110, (c == 2) ? 1'b1 : 1'b0);
            check($sformatf("fp c%0d gnt", c), 32'(gnt), 32'd2);
            if (c >= 3) begin
                check($sformatf("fp c%0d rdv", c), 32'(rd_valid), 32'd2);
                check($sformatf("fp c%0d rdd", c), 32'(rd_data),  32'd1);
            end
        end
        drive(4'b0100, 1'b0);
        check("fp only2 gnt", 32'(gnt), 32'd4);
        drive(4'b1100, 1'b0);
        check("fp 2over3 gnt", 32'(gnt), 32'd4);
        drive(4'b0000, 1'b0);
        check("fp idle gnt", 32'(gnt), 32'd0);
`else
        //            req      fs    gnt      rdv      rdd   busy  addr
        vecs[0]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 9'd0};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 9'd37};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 9'd37};
        vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 9'd37};
        vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, 9'd37};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0001, 4'b0000, 2'd1, 1'b0, 9'd37};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1, 9'd100};
        vecs[7]  = '{4'b1111, 1'b0, 4'b0100, 4'b0000, 2'd1, 1'b1, 9'd37};
        vecs[8]  = '{4'b1111, 1'b0, 4'b1000, 4'b0001, 2'd0, 1'b1, 9'd258};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0001, 4'b0010, 2'd1, 1'b1, 9'd511};
        vecs[10] = '{4'b1111, 1'b0, 4'b0010, 4'b0100, 2'd2, 1'b1, 9'd100};
        vecs[11] = '{4'b1010, 1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 9'd37};
        vecs[12] = '{4'b1010, 1'b0, 4'b0010, 4'b0001, 2'd0, 1'b1, 9'd511};
        vecs[13] = '{4'b1010, 1'b1, 4'b1000, 4'b0010, 2'd1, 1'b1, 9'd37};
        vecs[14] = '{4'b1010, 1'b0, 4'b0010, 4'b1000, 2'd3, 1'b1, 9'd511};
        vecs[15] = '{4'b0010, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 9'd37};
        vecs[16] = '{4'b1001, 1'b0, 4'b0001, 4'b1000, 2'd3, 1'b1, 9'd37};
        vecs[17] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 9'd100};
        vecs[18] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 2'd1, 1'b1, 9'd100};
        vecs[19] = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 2'd0, 1'b1, 9'd100};
        vecs[20] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 9'd100};

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].req, vecs[i].fs);
            check($sformatf("c%0d gnt", i),      32'(gnt),         32'(vecs[i].gnt));
            check($sformatf("c%0d rd_valid", i), 32'(rd_valid),    32'(vecs[i].rdv));
            check($sformatf("c%0d rd_data", i),  32'(rd_data),     32'(vecs[i].rdd));
            check($sformatf("c%0d busy", i),     32'(busy),        32'(vecs[i].busy));
            check($sformatf("c%0d rom_addr", i), 32'(rom_address), 32'(vecs[i].addr));
        end

        // Reset mid-flight: pointer is 1 here, so req 0100 grants 2.
        drive(4'b0100, 1'b0);
        check("rmf grant2", 32'(gnt), 32'd4);
        @(posedge vga_clk);
        #1;
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge vga_clk);
        check("rmf rd_valid", 32'(rd_valid),    32'd0);
        check("rmf busy",     32'(busy),        32'd0);
        check("rmf rom_addr", 32'(rom_address), 32'd0);
        check("rmf rd_data",  32'(rd_data),     32'd0);
        @(posedge vga_clk);
        #1;
        reset = 1'b0;
        @(negedge vga_clk);
        check("rmf T+2 rd_valid", 32'(rd_valid), 32'd0);
        check("rmf T+2 busy",     32'(busy),     32'd0);
        for (int c = 3; c <= 5; c++) begin
            drive(4'b0000, 1'b0);
            check($sformatf("rmf T+%0d rd_valid", c), 32'(rd_valid), 32'd0);
            check($sformatf("rmf T+%0d busy", c),     32'(busy),     32'd0);
        end
        // Pointer was 3 before reset; after reset it must start at 0.
        drive(4'b1111, 1'b0);
        check("post-rst ptr0 gnt", 32'(gnt), 32'd1);
        drive(4'b1000, 1'b0);
        check("post-rst gnt3", 32'(gnt), 32'd8);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
        check("post-rst rdv0", 32'(rd_valid), 32'd1);
        check("post-rst rdd0", 32'(rd_data),  32'd0);
        drive(4'b0000, 1'b0);
        check("post-rst rdv3", 32'(rd_valid), 32'd8);
        check("post-rst rdd3", 32'(rd_data),  32'd3);

        // Idle: everything quiet, address and data held.
        for (int c = 0; c < 10; c++) begin
            drive(4'b0000, 1'b0);
            check($sformatf("idle%0d gnt", c),      32'(gnt),         32'd0);
            check($sformatf("idle%0d rd_valid", c), 32'(rd_valid),    32'd0);
            check($sformatf("idle%0d rom_addr", c), 32'(rom_address), 32'd511);
            check($sformatf("idle%0d rd_data", c),  32'(rd_data),     32'd3);
            check($sformatf("idle%0d busy", c),     32'(busy),        32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
